// File: rtl/assoc_search_engine.sv
// Associative search engine: on-chip memory with a write port and a sequential
// masked content search (wrap-around, find-next, single-pass not-found).
module assoc_search_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WR_Ext,
  input  logic [ADDR_WIDTH-1:0] Wr_Addr,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  RD_Ext,
  input  logic [DATA_WIDTH-1:0] Key,
  input  logic [DATA_WIDTH-1:0] Mask,
  input  logic [ADDR_WIDTH-1:0] Start_Addr,
  input  logic                  Continue,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Found,
  output logic [ADDR_WIDTH-1:0] Match_Addr,
  output logic [ADDR_WIDTH:0]   Scan_Count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] LAST_CNT  = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, HIT} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] key_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [ADDR_WIDTH-1:0] ptr;

  logic [DATA_WIDTH-1:0] rdata_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic                  vld_p1;

  logic wr_en, rd_go, cont_go, cont_empty, hit, last_cmp;

  function automatic logic masked_eq(input logic [DATA_WIDTH-1:0] d,
                                     input logic [DATA_WIDTH-1:0] k,
                                     input logic [DATA_WIDTH-1:0] m);
    return (((d ^ k) & m) == '0);
  endfunction

  // A simultaneous write always beats a search start; nothing is accepted mid-scan.
  assign wr_en      = WR_Ext && (state != SCAN);
  assign rd_go      = RD_Ext && !WR_Ext && (state != SCAN);
  assign cont_go    = Continue && !RD_Ext && (state == HIT);
  assign cont_empty = cont_go && (Scan_Count == DEPTH_CNT);
  assign hit        = vld_p1 && masked_eq(rdata_p1, key_q, mask_q);
  assign last_cmp   = vld_p1 && (Scan_Count == LAST_CNT);

  assign Busy = (state == SCAN);

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (rd_go) state_nxt = SCAN;
      SCAN: begin
        if (hit)           state_nxt = HIT;
        else if (last_cmp) state_nxt = IDLE;
      end
      HIT: begin
        if (rd_go)           state_nxt = SCAN;
        else if (cont_empty) state_nxt = IDLE;
        else if (cont_go)    state_nxt = SCAN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0 -> p1: address issue and synchronous memory read
  always_ff @(posedge Clock) begin
    if (wr_en) mem[Wr_Addr] <= Data_in;
    rdata_p1 <= mem[ptr];
    addr_p1  <= ptr;
    if (rd_go) begin
      key_q  <= Key;
      mask_q <= Mask;
    end
    if (rd_go)               ptr <= Start_Addr;
    else if (cont_go)        ptr <= Match_Addr + 1'b1;
    else if (state == SCAN)  ptr <= ptr + 1'b1;
  end

  // p1 -> p2: registered compare result and search status
  always_ff @(posedge Clock) begin
    if (Reset) begin
      vld_p1     <= 1'b0;
      Done       <= 1'b0;
      Found      <= 1'b0;
      Match_Addr <= '0;
      Scan_Count <= '0;
    end else begin
      vld_p1 <= (state == SCAN) && (state_nxt == SCAN);
      Done   <= 1'b0;
      if (rd_go) begin
        Scan_Count <= '0;
        Found      <= 1'b0;
      end else if (cont_empty) begin
        Done  <= 1'b1;
        Found <= 1'b0;
      end else if (cont_go) begin
        Found <= 1'b0;
      end else if (vld_p1) begin
        Scan_Count <= Scan_Count + 1'b1;
        if (hit) begin
          Done       <= 1'b1;
          Found      <= 1'b1;
          Match_Addr <= addr_p1;
        end else if (last_cmp) begin
          Done  <= 1'b1;
          Found <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/assoc_search_engine.md
Name: assoc_search_engine

Overview:
- Parametrised associative memory search engine: on-chip DATA_WIDTH x 2^ADDR_WIDTH memory with a write port and a masked content search.
- A search scans entries sequentially from a programmable start address, one entry per cycle, with wrap-around.
- Terminates with a match address, or with a definite not-found after one full pass.
- Supports find-next (Continue) and per-bit don't-care masking. Sits between external host control and the address-consumer logic of the associative memory subsystem.

Parameters:
DATA_WIDTH, 8, width of each memory word, search key and mask
ADDR_WIDTH, 8, address width; DEPTH = 2^ADDR_WIDTH entries

Ports:
Clock  in  1  single clock, all logic on rising edge
Reset  in  1  synchronous, active-high reset
WR_Ext  in  1  write strobe: Mem[Wr_Addr] <= Data_in
Wr_Addr  in  ADDR_WIDTH  write address
Data_in  in  DATA_WIDTH  write data
RD_Ext  in  1  search start strobe
Key  in  DATA_WIDTH  search key, sampled on accepted RD_Ext
Mask  in  DATA_WIDTH  compare mask, 1 = bit compared; sampled with Key
Start_Addr  in  ADDR_WIDTH  first entry scanned
Continue  in  1  find-next request after a match
Busy  out  1  high while scanning
Done  out  1  one-cycle pulse at end of each search or continue leg
Found  out  1  result of last leg; valid from Done
Match_Addr  out  ADDR_WIDTH  address of matching entry
Scan_Count  out  ADDR_WIDTH+1  entries compared since the search was accepted

Behaviour:
- Reset: state IDLE; Busy, Done, Found, Match_Addr and Scan_Count all 0. Memory contents are not cleared. Reset mid-scan aborts with no Done pulse.
- States: IDLE, SCAN, HIT.
- IDLE:
  - WR_Ext writes memory. WR_Ext and RD_Ext together: the write wins and the search is dropped.
  - RD_Ext alone: latch Key and Mask, Ptr = Start_Addr, Scan_Count = 0, Found = 0, go to SCAN.
  - Continue is ignored.
- SCAN:
  - Busy = 1. Memory read is synchronous (1 cycle); the compare result is registered. Pipeline: address issue, then data, then compare.
  - Match condition: ((data ^ Key) & Mask) == 0. Ptr increments modulo DEPTH each cycle. Scan_Count increments per completed compare.
  - WR_Ext, RD_Ext and Continue are ignored.
- Timing: RD_Ext sampled at edge 0; entry at offset k (0-based from Start_Addr) is resolved at edge k+2. Throughput is 1 entry per cycle.
- On match: Done = 1 for one cycle, Found = 1, Match_Addr = matched address, Scan_Count = k+1, go to HIT. Any in-flight read is discarded.
- On no match after Scan_Count reaches DEPTH: Done pulse, Found = 0, Match_Addr unchanged, go to IDLE. Full miss resolves at edge DEPTH+1.
- HIT:
  - Busy = 0; writes are allowed.
  - RD_Ext starts a new search exactly as from IDLE. RD_Ext and Continue together: RD_Ext wins.
  - Continue resumes SCAN from Match_Addr+1 (mod DEPTH). Found clears; Scan_Count and Key/Mask are retained. The next resolved entry appears 2 cycles after Continue is sampled.
  - Continue with Scan_Count == DEPTH: no scan; Done with Found = 0 on the next edge, go to IDLE.
- Writes performed in HIT to not-yet-scanned entries are seen by a continued scan.
- Mask == 0: the Start_Addr entry matches, Done at edge 2.
- Found, Match_Addr and Scan_Count hold between Done and the next accepted RD_Ext/Continue or Reset.
- The bench must preload all entries before searching; unwritten entries compare as unknown.

Test Plan:
1. Preload Mem[i] = i for all 256 entries. Search Key = 0x10, Mask = 0xFF, Start_Addr = 0x00 -> Busy for cycles 1..18, Done at edge 18, Found = 1, Match_Addr = 0x10, Scan_Count = 17.
2. Same memory, Start_Addr = 0xF0, Key = 0x05 -> wraps; Match_Addr = 0x05, Scan_Count = 22, Done at edge 23.
3. Overwrite Mem[0x33] = 0x34, then search Key = 0x33 from 0x00 -> Done at edge 257, Found = 0, Scan_Count = 256, return to IDLE, Match_Addr unchanged.
4. Mem[i] = i, Mask = 0x0F, Key = 0x03, start 0x00; issue Continue after each hit -> Match_Addr sequence 0x03, 0x13, ..., 0xF3 (16 hits). Next Continue -> Done, Found = 0, Scan_Count = 256.
5. WR_Ext and RD_Ext together in IDLE -> memory written, Busy stays 0, no Done. WR_Ext during SCAN -> memory unchanged, as verified by a later search.
6. Reset asserted at cycle 50 of a miss scan -> next cycle Busy = 0, Done = 0, Found = 0, Scan_Count = 0. A new RD_Ext is accepted normally.
